// File: rtl/apb_req_sequencer_if.sv
// Signal bundle between two local requesters, apb_req_sequencer and one APB slave.
// Requester arrays are indexed by requester number (0 or 1).
interface apb_req_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [1:0]             req_valid;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0][STRB_W-1:0] req_strb;
    logic [1:0][2:0]        req_prot;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_valid;
    logic [1:0][DATA_W-1:0] rsp_rdata;
    logic [1:0]             rsp_err;

    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pwdata;
    logic [STRB_W-1:0]      pstrb;
    logic [2:0]             pprot;
    logic                   pready;
    logic                   pslverr;
    logic [DATA_W-1:0]      prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  pready, pslverr, prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output pready, pslverr, prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
    );
endinterface

// File: rtl/apb_req_sequencer.sv
// Round-robin two-requester APB master: SETUP/ACCESS sequencing, wait states,
// wait-state timeout, and per-requester response pulses. All outputs are flops.
module apb_req_sequencer #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    apb_req_sequencer_if.master bus
);
    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_last, w_last_nxt;
    logic                   r_id, w_id_nxt;
    logic [7:0]             r_cnt, w_cnt_nxt;
    logic [1:0]             r_ready, w_ready_nxt;
    logic [1:0]             r_rsp_valid, w_rsp_valid_nxt;
    logic [1:0][DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
    logic [1:0]             r_rsp_err, w_rsp_err_nxt;
    logic                   r_psel, w_psel_nxt;
    logic                   r_penable, w_penable_nxt;
    logic                   r_pwrite, w_pwrite_nxt;
    logic [ADDR_W-1:0]      r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0]      r_pwdata, w_pwdata_nxt;
    logic [STRB_W-1:0]      r_pstrb, w_pstrb_nxt;
    logic [2:0]             r_pprot, w_pprot_nxt;

    logic w_any, w_win, w_sel, w_take;

    // r_last is the last granted requester; on a tie the other one wins.
    assign w_any  = |bus.req_valid;
    assign w_win  = (&bus.req_valid) ? ~r_last : bus.req_valid[1];
    assign w_sel  = r_ready[1];
    assign w_take = |(r_ready & bus.req_valid);

    always_comb begin
        w_state_nxt     = r_state;
        w_last_nxt      = r_last;
        w_id_nxt        = r_id;
        w_cnt_nxt       = r_cnt;
        w_ready_nxt     = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = '0;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_pwrite_nxt    = r_pwrite;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pstrb_nxt     = r_pstrb;
        w_pprot_nxt     = r_pprot;
        unique case (r_state)
            IDLE: begin
                // The ready pulse is the accept cycle; capture happens on its closing edge.
                if (w_take) begin
                    w_id_nxt      = w_sel;
                    w_last_nxt    = w_sel;
                    w_pwrite_nxt  = bus.req_write[w_sel];
                    w_paddr_nxt   = bus.req_addr[w_sel];
                    w_pwdata_nxt  = bus.req_write[w_sel] ? bus.req_wdata[w_sel] : '0;
                    w_pstrb_nxt   = bus.req_write[w_sel] ? bus.req_strb[w_sel] : '0;
                    w_pprot_nxt   = bus.req_prot[w_sel];
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = SETUP;
                end else if (!(|r_ready) && w_any) begin
                    w_ready_nxt = w_win ? 2'b10 : 2'b01;
                end
            end
            SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    w_rsp_valid_nxt        = r_id ? 2'b10 : 2'b01;
                    w_rsp_rdata_nxt[r_id]  = r_pwrite ? '0 : bus.prdata;
                    w_rsp_err_nxt[r_id]    = bus.pslverr;
                    w_psel_nxt             = 1'b0;
                    w_penable_nxt          = 1'b0;
                    w_state_nxt            = RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_rsp_valid_nxt        = r_id ? 2'b10 : 2'b01;
                    w_rsp_err_nxt[r_id]    = 1'b1;
                    w_psel_nxt             = 1'b0;
                    w_penable_nxt          = 1'b0;
                    w_state_nxt            = RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            RESP: begin
                // Arbitrating here keeps back-to-back accepts four cycles apart.
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
                if (w_any) w_ready_nxt = w_win ? 2'b10 : 2'b01;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
            r_cnt       <= '0;
            r_ready     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_last      <= w_last_nxt;
            r_id        <= w_id_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ready     <= w_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pstrb     <= w_pstrb_nxt;
            r_pprot     <= w_pprot_nxt;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.psel      = r_psel;
    assign bus.penable   = r_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.pstrb     = r_pstrb;
    assign bus.pprot     = r_pprot;
endmodule

// File: tb/tb_apb_req_sequencer.sv
// Directed-sequence bench for apb_req_sequencer with randomized request data and
// slave responses, checked against a transfer-level timing/arbitration model.
module tb_apb_req_sequencer;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_fail = 0;
    logic m_last;   // model: last granted requester

    always #5 clk = ~clk;

    apb_req_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_req_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rand_req(input int n);
        bus.req_write[n] = 1'($urandom);
        bus.req_addr[n]  = ADDR_W'($urandom);
        bus.req_wdata[n] = $urandom;
        bus.req_strb[n]  = STRB_W'($urandom);
        bus.req_prot[n]  = 3'($urandom);
    endtask

    // One complete transfer: accept, SETUP, waits+1 ACCESS cycles (capped by timeout), response.
    task automatic run_xfer(input logic v0, input logic v1, input logic stay,
                            input int waits, input logic serr, input logic [31:0] rd);
        logic              w;
        logic              wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        logic [STRB_W-1:0] sb;
        logic [2:0]        pr;
        logic              tmo;
        int                last_k;
        logic [31:0]       exp_rd;
        w  = (v0 && v1) ? ~m_last : v1;
        wr = bus.req_write[w];
        a  = bus.req_addr[w];
        wd = wr ? bus.req_wdata[w] : '0;
        sb = wr ? bus.req_strb[w] : '0;
        pr = bus.req_prot[w];
        tmo    = (waits >= TIMEOUT);
        last_k = tmo ? TIMEOUT - 1 : waits;
        exp_rd = (tmo || wr) ? 32'h0 : rd;
        bus.req_valid = {v1, v0};
        tick();
        chk("accept_ready", 32'(bus.req_ready), w ? 32'h2 : 32'h1);
        chk("accept_rsp", 32'(bus.rsp_valid), 32'h0);
        chk("accept_psel", 32'(bus.psel), 32'h0);
        tick();
        m_last = w;
        if (!stay) bus.req_valid[w] = 1'b0;
        rand_req(0);
        rand_req(1);
        bus.pready  = 1'($urandom);
        bus.pslverr = 1'($urandom);
        bus.prdata  = $urandom;
        chk("setup_psel", 32'(bus.psel), 32'h1);
        chk("setup_penable", 32'(bus.penable), 32'h0);
        chk("setup_paddr", 32'(bus.paddr), 32'(a));
        chk("setup_pwrite", 32'(bus.pwrite), 32'(wr));
        chk("setup_pwdata", bus.pwdata, wd);
        chk("setup_pstrb", 32'(bus.pstrb), 32'(sb));
        chk("setup_pprot", 32'(bus.pprot), 32'(pr));
        chk("setup_ready", 32'(bus.req_ready), 32'h0);
        for (int k = 0; k <= last_k; k++) begin
            tick();
            chk("access_psel", 32'(bus.psel), 32'h1);
            chk("access_penable", 32'(bus.penable), 32'h1);
            chk("access_paddr", 32'(bus.paddr), 32'(a));
            chk("access_pwdata", bus.pwdata, wd);
            chk("access_pstrb", 32'(bus.pstrb), 32'(sb));
            chk("access_rsp", 32'(bus.rsp_valid), 32'h0);
            chk("access_ready", 32'(bus.req_ready), 32'h0);
            bus.pready  = (k == waits);
            bus.pslverr = (k == waits) ? serr : 1'($urandom);
            bus.prdata  = (k == waits) ? rd : $urandom;
        end
        tick();
        bus.pready = 1'b0;
        chk("resp_valid", 32'(bus.rsp_valid), w ? 32'h2 : 32'h1);
        chk("resp_rdata", bus.rsp_rdata[w], exp_rd);
        chk("resp_err", 32'(bus.rsp_err[w]), 32'(tmo ? 1'b1 : serr));
        chk("resp_other_err", 32'(bus.rsp_err[~w]), 32'h0);
        chk("resp_psel", 32'({bus.psel, bus.penable}), 32'h0);
        chk("resp_ready", 32'(bus.req_ready), 32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        m_last        = 1'b1;
        bus.req_valid = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        bus.prdata    = '0;
        rand_req(0);
        rand_req(1);
        repeat (3) tick();
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 32'h0);
        chk("rst_rdata0", bus.rsp_rdata[0], 32'h0);
        chk("rst_rdata1", bus.rsp_rdata[1], 32'h0);
        chk("rst_apb_ctl", 32'({bus.psel, bus.penable, bus.pwrite}), 32'h0);
        chk("rst_apb_addr", 32'({bus.paddr, bus.pstrb, bus.pprot}), 32'h0);
        chk("rst_pwdata", bus.pwdata, 32'h0);
        reset = 1'b0;

        // Zero-wait write from requester 0
        bus.req_write[0] = 1'b1;
        bus.req_addr[0]  = 5'h04;
        bus.req_wdata[0] = 32'hDEADBEEF;
        bus.req_strb[0]  = 4'hF;
        bus.req_prot[0]  = 3'b010;
        run_xfer(1'b1, 1'b0, 1'b0, 0, 1'b0, $urandom);

        // Read from requester 1 with three wait states
        bus.req_write[1] = 1'b0;
        bus.req_addr[1]  = 5'h10;
        run_xfer(1'b0, 1'b1, 1'b0, 3, 1'b0, 32'h12345678);

        // Contention: both held valid, expect strict alternation starting with 0
        for (int i = 0; i < 6; i++)
            run_xfer(1'b1, 1'b1, 1'b1, int'($urandom_range(0, 3)), 1'($urandom), $urandom);

        // Slave error, then a normal transfer
        bus.req_write[0] = 1'b1;
        bus.req_addr[0]  = 5'h1F;
        run_xfer(1'b1, 1'b0, 1'b0, 0, 1'b1, $urandom);
        run_xfer(1'b1, 1'b0, 1'b0, 1, 1'b0, $urandom);

        // pready on the last allowed cycle completes normally; beyond that it times out
        run_xfer(1'b0, 1'b1, 1'b0, TIMEOUT - 1, 1'b0, $urandom);
        bus.req_write[0] = 1'b0;
        run_xfer(1'b1, 1'b0, 1'b0, TIMEOUT + 4, 1'b0, $urandom);
        run_xfer(1'b1, 1'b1, 1'b0, 0, 1'b0, $urandom);

        for (int i = 0; i < 30; i++) begin
            int          vv;
            int          r;
            vv = int'($urandom_range(1, 3));
            r  = int'($urandom_range(0, 9));
            run_xfer(vv[0], vv[1], 1'($urandom), (r == 9) ? TIMEOUT + 2 : r % 5,
                     1'($urandom), $urandom);
        end

        // Reset during the second ACCESS wait cycle of a requester-0 transfer
        bus.req_valid = 2'b01;
        tick();
        chk("mid_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        bus.pready    = 1'b0;
        tick();
        tick();
        chk("mid_penable", 32'(bus.penable), 32'h1);
        reset = 1'b1;
        tick();
        chk("mid_rst_psel", 32'({bus.psel, bus.penable}), 32'h0);
        chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        bus.req_valid = 2'b11;
        tick();
        chk("mid_rst_rsp2", 32'(bus.rsp_valid), 32'h0);
        reset  = 1'b0;
        m_last = 1'b1;
        run_xfer(1'b1, 1'b1, 1'b0, 1, 1'b0, $urandom);
        bus.req_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
